// File: rtl/button_debouncer_if.sv
// button_debouncer_if: button bundle; master drives bt_in, slave returns bt_out/bt_rise/bt_fall
interface button_debouncer_if;
  logic bt_in;
  logic bt_out;
  logic bt_rise;
  logic bt_fall;
  modport master (output bt_in, input bt_out, input bt_rise, input bt_fall);
  modport slave (input bt_in, output bt_out, output bt_rise, output bt_fall);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop sync + 4-state qualify FSM; ports clk, rst, bus.bt_in -> bus.bt_out/bt_rise/bt_fall
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH = 19
) (
  input logic clk,
  input logic rst,
  button_debouncer_if.slave bus
);
  typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_t state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic sync1_q, sync0_q, out_q, rise_q, fall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync0_q <= 1'b0;
      state_q <= STABLE_LOW;
      cnt_q <= '0;
      out_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1_q <= bus.bt_in;
      sync0_q <= sync1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LOW: begin
          state_q <= sync0_q ? WAIT_HIGH : STABLE_LOW;
          cnt_q <= sync0_q ? ONE : '0;
        end
        WAIT_HIGH:
          if (!sync0_q) begin
            state_q <= STABLE_LOW;
            cnt_q <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= STABLE_HIGH;
            cnt_q <= '0;
            out_q <= 1'b1;
            rise_q <= 1'b1;
          end else cnt_q <= cnt_q + ONE;
        STABLE_HIGH: begin
          state_q <= sync0_q ? STABLE_HIGH : WAIT_LOW;
          cnt_q <= sync0_q ? '0 : ONE;
        end
        WAIT_LOW:
          if (sync0_q) begin
            state_q <= STABLE_HIGH;
            cnt_q <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= STABLE_LOW;
            cnt_q <= '0;
            out_q <= 1'b0;
            fall_q <= 1'b1;
          end else cnt_q <= cnt_q + ONE;
      endcase
    end
  end
  assign bus.bt_out = out_q;
  assign bus.bt_rise = rise_q;
  assign bus.bt_fall = fall_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of {bt_out,bt_rise,bt_fall} with N=4
module tb_button_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [5:0] pat = 6'b101101;
  button_debouncer_if bus();
  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {bus.bt_out, bus.bt_rise, bus.bt_fall};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    bus.bt_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", 3'b000);
    end
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("reset_release_rise", k == 5 ? 3'b110 : k == 6 ? 3'b100 : 3'b000);
    end
    bus.bt_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("clean_release", k < 5 ? 3'b100 : k == 5 ? 3'b001 : 3'b000);
    end
    for (int k = 0; k < 11; k++) begin
      bus.bt_in = k < 3;
      step();
      check("glitch3", 3'b000);
    end
    for (int k = 0; k < 11; k++) begin
      bus.bt_in = k < 4;
      step();
      check("pulse4", k < 5 ? 3'b000 : k == 5 ? 3'b110 : k < 9 ? 3'b100 : k == 9 ? 3'b001 : 3'b000);
    end
    for (int k = 0; k < 12; k++) begin
      bus.bt_in = k < 6 ? pat[k] : 1'b1;
      step();
      check("bounce", k == 10 ? 3'b110 : k == 11 ? 3'b100 : 3'b000);
    end
    rst = 1'b1;
    step();
    check("reset_mid_high", 3'b000);
    rst = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      check("rise_after_reset", k == 6 ? 3'b110 : k == 7 ? 3'b100 : 3'b000);
    end
    bus.bt_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("release_again", k < 5 ? 3'b100 : k == 5 ? 3'b001 : 3'b000);
    end
    bus.bt_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("qualify_partial", 3'b000);
    end
    rst = 1'b1;
    step();
    check("reset_mid_qualify", 3'b000);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("requalify", k == 5 ? 3'b110 : k == 6 ? 3'b100 : 3'b000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Upstream conditioning stage for every front-panel push-button: it brings an asynchronous, bouncing contact into the `clk` domain and qualifies it. Its level output `bt_out` feeds `bt_in` of the edge-detect / one-pulse stage. It also provides its own registered rise/fall strobes for consumers that need release events. Each button has one instance.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a new level (10 ms at 50 MHz). Legal range ≥ 2.
- `CNT_WIDTH`, default 19: stability-counter width. Must satisfy 2^CNT_WIDTH ≥ DEBOUNCE_CYCLES.
- `clk`, input, 1: system clock. Every register is updated on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `bt_in`, input, 1: raw button contact. It is asynchronous and may bounce.
- `bt_out`, output, 1: debounced level, registered.
- `bt_rise`, output, 1: one-cycle strobe in the cycle `bt_out` goes 0→1, registered.
- `bt_fall`, output, 1: one-cycle strobe in the cycle `bt_out` goes 1→0, registered.

## Operation
- **Synchronizer:** two flops, `sync1 <= bt_in` and `sync0 <= sync1`. Nothing else samples `bt_in`. The FSM and counter use only `sync0`.
- **FSM states:** STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. `cnt` is `CNT_WIDTH` bits.
  - **STABLE_LOW:** if `sync0`=1, go to WAIT_HIGH with `cnt`=1. Otherwise stay with `cnt`=0.
  - **WAIT_HIGH, `sync0`=0:** go to STABLE_LOW with `cnt`=0. The glitch is rejected and no strobe is issued.
  - **WAIT_HIGH, `sync0`=1 and `cnt`=DEBOUNCE_CYCLES-1:** go to STABLE_HIGH and set `bt_out`=1, `bt_rise`=1, `cnt`=0.
  - **WAIT_HIGH, `sync0`=1 otherwise:** increment `cnt`.
  - **STABLE_HIGH and WAIT_LOW:** mirror image of the above. Acceptance sets `bt_out`=0 and `bt_fall`=1.
- **Strobes:** `bt_rise` and `bt_fall` are high for exactly one cycle and default to 0 in every other cycle. They are never high together. Each is high only in the cycle where `bt_out` has just changed, matching its direction.
- **`bt_out`:** changes only on acceptance transitions. It equals 1 iff the state is STABLE_HIGH or WAIT_LOW.
- **Counter range:** `cnt` never exceeds DEBOUNCE_CYCLES-1. Wrap-around is impossible by construction.
- **Reset:** when `rst`=1 at a clock edge, the next state is as follows, whatever the current state:
  - `sync1`, `sync0` = 0.
  - State = STABLE_LOW, `cnt` = 0.
  - `bt_out`, `bt_rise`, `bt_fall` = 0.
- **Reset mid-operation:** no `bt_fall` is generated when reset clears a high `bt_out`.
- **Button held through reset release:** it is re-qualified from scratch. It produces a normal `bt_rise` after the full latency.
- **Reset priority:** `rst` has priority over all other activity in the same cycle.

## Timing
- Let N = DEBOUNCE_CYCLES.
- **Rise latency:** `bt_in` is stable 1 before rising edge 0, with prior state STABLE_LOW.
  - Edge 0: `sync1`=1.
  - Edge 1: `sync0`=1.
  - Edge 2: WAIT_HIGH, `cnt`=1.
  - Edge N+1: `bt_out`=1 and `bt_rise`=1.
  - Edge N+2: `bt_rise`=0.
  - Total latency is N+2 edges.
- **Fall latency:** identical, with `bt_fall`.
- **Rejection rule:** a pulse or bounce on `bt_in` is rejected if `sync0` holds it for fewer than N consecutive cycles. A pulse of N or more cycles is accepted.
- **Bouncing edge:** the counter restarts from the first sample of the final stable run.
- **Toggle rate:** the minimum spacing between a `bt_rise` and the next `bt_fall` is N cycles.
- **Startup:** all outputs read 0 in the cycle after reset is applied.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and CNT_WIDTH=3.
1. **Reset:** hold `rst`=1 for 3 cycles with `bt_in`=1 → `bt_out`, `bt_rise`, `bt_fall` all 0 throughout. After release, `bt_out`=1 and `bt_rise`=1 exactly after edge 5 counted from release, and `bt_rise`=0 after edge 6.
2. **Clean press and release:** `bt_in` 0→1 before edge 0 → `bt_out`=1 and `bt_rise`=1 after edge 5 only. Then `bt_in`=0 before edge 20 → `bt_out`=0 and `bt_fall`=1 after edge 25 only.
3. **Glitch rejection:** from STABLE_LOW, pulse `bt_in` high for 3 cycles → `bt_out` stays 0 and no strobes occur. A 4-cycle pulse → `bt_rise` occurs once and `bt_out`=1.
4. **Bounce:** `bt_in` sequence 1,0,1,1,0,1 then steady 1 → exactly one `bt_rise`. It occurs 5 edges after the edge that sampled the final 0→1.
5. **Reset mid-operation:** `bt_out`=1, then assert `rst` for 1 cycle → `bt_out`=0 and no `bt_fall`. With `bt_in` still 1, a new `bt_rise` comes 6 edges after the reset edge.
6. **Reset mid-qualification:** with `cnt`=2 in WAIT_HIGH, assert `rst` → state returns to STABLE_LOW with `cnt`=0. The full N+2 latency restarts from reset release.
